sm_axil_ctrl_slave: RTL and testbench

//  AXI4-Lite slave (responder) for the SM control register bank; sits behind the AXI interconnect and is driven by the PS or an AXI VIP master.

---
 rtl/sm_axil_pkg.sv | 44 ++++
 rtl/sm_irq_bank.sv | 57 +++++
 rtl/sm_axil_ctrl_slave.sv | 218 +++++++++++++++++++++
 tb/tb_sm_axil_ctrl_slave.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_axil_pkg.sv
// Shared definitions for the SM control-register AXI4-Lite slave:
// register offsets, response codes, channel FSM state encodings.
package sm_axil_pkg;

    localparam logic [4:0] OFF_CTRL0    = 5'h00;
    localparam logic [4:0] OFF_CTRL1    = 5'h04;
    localparam logic [4:0] OFF_CTRL2    = 5'h08;
    localparam logic [4:0] OFF_CTRL3    = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;
    localparam logic [4:0] OFF_IRQ_PEND = 5'h14;
    localparam logic [4:0] OFF_IRQ_EN   = 5'h18;
    localparam logic [4:0] OFF_ID       = 5'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_COMMIT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    function automatic logic [2:0] word_of(input logic [4:0] off);
        return off[4:2];
    endfunction

    // Expand byte strobes into a per-bit write mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sm_irq_bank.sv
// Interrupt pending/enable registers: W1C pending with set-over-clear priority,
// byte-masked enable writes and a registered level interrupt output.
module sm_irq_bank #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] evt,
    input  logic             pend_clr,
    input  logic             en_wr,
    input  logic [31:0]      wdata,
    input  logic [31:0]      wmask,
    output logic [31:0]      pend,
    output logic [31:0]      en,
    output logic             irq
);
    logic [N_IRQ-1:0] pend_reg;
    logic [N_IRQ-1:0] en_reg;
    logic             irq_reg;
    logic [N_IRQ-1:0] clr_bits;
    logic [N_IRQ-1:0] wr_bits;
    logic [N_IRQ-1:0] wr_mask;

    assign wr_bits  = wdata[N_IRQ-1:0];
    assign wr_mask  = wmask[N_IRQ-1:0];
    assign clr_bits = pend_clr ? (wr_bits & wr_mask) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= '0;
            en_reg   <= '0;
            irq_reg  <= 1'b0;
        end else begin
            // OR-ing events in after the clear lets a same-cycle event win.
            pend_reg <= (pend_reg & ~clr_bits) | evt;
            if (en_wr) begin
                en_reg <= (en_reg & ~wr_mask) | (wr_bits & wr_mask);
            end
            irq_reg <= |(pend_reg & en_reg);
        end
    end

    generate
        if (N_IRQ < 32) begin : g_pad
            logic unused_hi;
            assign pend      = {{(32-N_IRQ){1'b0}}, pend_reg};
            assign en        = {{(32-N_IRQ){1'b0}}, en_reg};
            assign unused_hi = ^{wdata[31:N_IRQ], wmask[31:N_IRQ]};
        end else begin : g_full
            assign pend = pend_reg;
            assign en   = en_reg;
        end
    endgenerate

    assign irq = irq_reg;

endmodule

// File: rtl/sm_axil_ctrl_slave.sv
// AXI4-Lite slave for the SM control register bank: independent write/read
// channel FSMs, address decode, CTRL0..3 storage and the interrupt bank.
module sm_axil_ctrl_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          N_IRQ              = 8,
    parameter logic [31:0] ID_VALUE           = 32'h534D_0100
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [3:0][31:0]                ctrl_o,
    input  logic [31:0]                     status_i,
    input  logic [N_IRQ-1:0]                irq_evt_i,
    output logic                            irq_o
);
    import sm_axil_pkg::*;

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic clk;
    logic rst_n;
    assign clk   = S_AXI_ACLK;
    assign rst_n = S_AXI_ARESETN;

    w_state_t w_state_reg, w_state_next;
    r_state_t r_state_reg, r_state_next;

    logic          awready_reg, awready_next;
    logic          wready_reg, wready_next;
    logic          bvalid_reg, bvalid_next;
    logic [1:0]    bresp_reg;
    logic          arready_reg, arready_next;
    logic          rvalid_reg, rvalid_next;
    logic [1:0]    rresp_reg;
    logic [31:0]   rdata_reg;

    logic [AW-3:0] aw_addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    wstrb_reg;

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = S_AXI_AWVALID & awready_reg;
    assign w_hs  = S_AXI_WVALID  & wready_reg;
    assign ar_hs = S_AXI_ARVALID & arready_reg;

    logic unused_in;
    assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ---------------- write channel ----------------
    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs)  w_state_next = W_COMMIT;
                else if (aw_hs)     w_state_next = W_HAVE_AW;
                else if (w_hs)      w_state_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)  w_state_next = W_COMMIT;
            W_HAVE_W:  if (aw_hs) w_state_next = W_COMMIT;
            W_COMMIT:  w_state_next = W_RESP;
            W_RESP:    if (S_AXI_BREADY) w_state_next = W_IDLE;
            default:   w_state_next = W_IDLE;
        endcase
        awready_next = (w_state_next == W_IDLE) || (w_state_next == W_HAVE_W);
        wready_next  = (w_state_next == W_IDLE) || (w_state_next == W_HAVE_AW);
        bvalid_next  = (w_state_next == W_RESP);
    end

    logic        wr_commit;
    logic        wr_mapped;
    logic [2:0]  wr_word;
    logic [31:0] wr_mask;
    logic        wr_hit_ctrl;

    assign wr_commit   = (w_state_reg == W_COMMIT);
    assign wr_mapped   = (aw_addr_reg[AW-3:3] == '0);
    assign wr_word     = aw_addr_reg[2:0];
    assign wr_mask     = strb_mask(wstrb_reg);
    assign wr_hit_ctrl = wr_commit && wr_mapped && !wr_word[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            aw_addr_reg <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            w_state_reg <= w_state_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
            if (aw_hs) aw_addr_reg <= S_AXI_AWADDR[AW-1:2];
            if (w_hs) begin
                wdata_reg <= S_AXI_WDATA;
                wstrb_reg <= S_AXI_WSTRB;
            end
            if (wr_commit) bresp_reg <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ctrl
            logic [31:0] word_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_hit_ctrl && wr_word[1:0] == 2'(gi)) begin
                    word_reg <= (word_reg & ~wr_mask) | (wdata_reg & wr_mask);
                end
            end
            assign ctrl_o[gi] = word_reg;
        end
    endgenerate

    // ---------------- interrupt bank ----------------
    logic [31:0] pend_word;
    logic [31:0] en_word;

    sm_irq_bank #(
        .N_IRQ (N_IRQ)
    ) u_irq_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt      (irq_evt_i),
        .pend_clr (wr_commit && wr_mapped && wr_word == word_of(OFF_IRQ_PEND)),
        .en_wr    (wr_commit && wr_mapped && wr_word == word_of(OFF_IRQ_EN)),
        .wdata    (wdata_reg),
        .wmask    (wr_mask),
        .pend     (pend_word),
        .en       (en_word),
        .irq      (irq_o)
    );

    // ---------------- read channel ----------------
    logic        rd_mapped;
    logic [2:0]  rd_word;
    logic [31:0] rd_value;

    always_comb begin
        rd_mapped = (S_AXI_ARADDR[AW-1:5] == '0);
        rd_word   = S_AXI_ARADDR[4:2];
        rd_value  = '0;
        if (!rd_word[2]) begin
            rd_value = ctrl_o[rd_word[1:0]];
        end else begin
            case (rd_word)
                word_of(OFF_STATUS):   rd_value = status_i;
                word_of(OFF_IRQ_PEND): rd_value = pend_word;
                word_of(OFF_IRQ_EN):   rd_value = en_word;
                default:               rd_value = ID_VALUE;
            endcase
        end
        if (!rd_mapped) rd_value = '0;
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
        arready_next = (r_state_next == R_IDLE);
        rvalid_next  = (r_state_next == R_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= arready_next;
            rvalid_reg  <= rvalid_next;
            if (ar_hs) begin
                rdata_reg <= rd_value;
                rresp_reg <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RDATA   = rdata_reg;

endmodule

// File: tb/tb_sm_axil_ctrl_slave.sv
// Directed bench for sm_axil_ctrl_slave: expected B/R responses are queued by
// the stimulus and checked by a separate monitor at each response handshake.
module tb_sm_axil_ctrl_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [5:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [3:0][31:0] ctrl;
    logic [31:0] status = '0;
    logic [7:0]  irq_evt = '0;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] resp;
        string      name;
    } b_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];

    always #5 clk = ~clk;

    sm_axil_ctrl_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_o        (ctrl),
        .status_i      (status),
        .irq_evt_i     (irq_evt),
        .irq_o         (irq)
    );

    // Response monitor: sampled on the falling edge, ahead of the handshake edge.
    always @(negedge clk) begin
        b_exp_t be;
        r_exp_t re;
        if (bvalid && bready) begin
            n_vec++;
            if (b_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_b: got bresp=%0d, required no response", bresp);
            end else begin
                be = b_q.pop_front();
                if (bresp !== be.resp) begin
                    n_err++;
                    $display("FAIL %s: bresp got %0d, required %0d", be.name, bresp, be.resp);
                end else begin
                    $display("B   %-14s bresp=%0d", be.name, bresp);
                end
            end
        end
        if (rvalid && rready) begin
            n_vec++;
            if (r_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_r: got rdata=%h, required no response", rdata);
            end else begin
                re = r_q.pop_front();
                if (rdata !== re.data || rresp !== re.resp) begin
                    n_err++;
                    $display("FAIL %s: got rdata=%h rresp=%0d, required rdata=%h rresp=%0d",
                             re.name, rdata, rresp, re.data, re.resp);
                end else begin
                    $display("R   %-14s rdata=%h rresp=%0d", re.name, rdata, rresp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end else begin
            $display("CHK %-14s %h", name, got);
        end
    endtask

    task automatic send_aw(input logic [5:0] a);
        int k;
        k = 0;
        awaddr  = a;
        awvalid = 1'b1;
        @(negedge clk);
        while (!awready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!awready) check("aw_timeout", {31'b0, awready}, 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int k;
        k = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        @(negedge clk);
        while (!wready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!wready) check("w_timeout", {31'b0, wready}, 32'd1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] a);
        int k;
        k = 0;
        araddr  = a;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!arready) check("ar_timeout", {31'b0, arready}, 32'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp, input string name);
        b_q.push_back('{resp: resp, name: name});
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input string name);
        r_q.push_back('{data: d, resp: resp, name: name});
        send_ar(a);
    endtask

    task automatic wait_b();
        int k;
        k = 0;
        while (b_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (b_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL b_timeout: got no B response, required %0d outstanding", b_q.size());
            b_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_r();
        int k;
        k = 0;
        while (r_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (r_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL r_timeout: got no R response, required %0d outstanding", r_q.size());
            r_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_wait(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [1:0] resp, input string name);
        axi_write(a, d, s, resp, name);
        wait_b();
    endtask

    task automatic read_wait(input logic [5:0] a, input logic [31:0] d, input logic [1:0] resp,
                             input string name);
        axi_read(a, d, resp, name);
        wait_r();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready",  {31'b0, wready},  32'd0);
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_valids",  {30'b0, bvalid, rvalid}, 32'd0);
        check("rst_resps",   {28'b0, bresp, rresp}, 32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_irq",     {31'b0, irq}, 32'd0);
        for (int i = 0; i < 4; i++) check("rst_ctrl", ctrl[i], 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_awready", {31'b0, awready}, 32'd0);
        @(posedge clk);
        #1;
        check("rdy_after_edge", {29'b0, awready, wready, arready}, 32'd7);

        // ---- 1: CTRL write / read back ----
        for (int i = 0; i < 4; i++) write_wait(6'(i * 4), 32'(i + 1), 4'hF, 2'b00, "wr_ctrl");
        for (int i = 0; i < 4; i++) check("ctrl_o", ctrl[i], 32'(i + 1));
        for (int i = 0; i < 4; i++) read_wait(6'(i * 4), 32'(i + 1), 2'b00, "rd_ctrl");

        // ---- 2: W before AW with a single byte strobe ----
        write_wait(6'h04, 32'h0, 4'hF, 2'b00, "clr_ctrl1");
        b_q.push_back('{resp: 2'b00, name: "w_first"});
        send_w(32'hAABB_CCDD, 4'b0010);
        check("have_w_rdy", {30'b0, awready, wready}, 32'd2);
        repeat (3) begin
            check("no_early_b", {31'b0, bvalid}, 32'd0);
            @(posedge clk);
            #1;
        end
        send_aw(6'h04);
        wait_b();
        check("ctrl1_strb", ctrl[1], 32'h0000_CC00);
        read_wait(6'h04, 32'h0000_CC00, 2'b00, "rd_ctrl1");

        // ---- 3: interrupts ----
        write_wait(6'h18, 32'hFFFF_FFFF, 4'hF, 2'b00, "en_all");
        read_wait(6'h18, 32'h0000_00FF, 2'b00, "rd_en_all");
        write_wait(6'h18, 32'h0000_0008, 4'hF, 2'b00, "en_bit3");
        irq_evt = 8'h08;
        @(posedge clk);
        #1;
        irq_evt = 8'h00;
        check("irq_lag", {31'b0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check("irq_set", {31'b0, irq}, 32'd1);
        read_wait(6'h14, 32'h0000_0008, 2'b00, "rd_pend");
        axi_write(6'h14, 32'h0000_0008, 4'hF, 2'b00, "w1c_vs_evt");
        irq_evt = 8'h08;
        @(posedge clk);
        #1;
        irq_evt = 8'h00;
        wait_b();
        read_wait(6'h14, 32'h0000_0008, 2'b00, "pend_set_wins");
        check("irq_held", {31'b0, irq}, 32'd1);
        write_wait(6'h14, 32'h0000_0008, 4'b1110, 2'b00, "w1c_nostrb");
        read_wait(6'h14, 32'h0000_0008, 2'b00, "pend_kept");
        write_wait(6'h14, 32'h0000_0008, 4'hF, 2'b00, "w1c_clear");
        read_wait(6'h14, 32'h0000_0000, 2'b00, "pend_cleared");
        check("irq_clr", {31'b0, irq}, 32'd0);

        // ---- 4: unmapped and read-only words ----
        status = 32'h1234_5678;
        read_wait(6'h24, 32'h0, 2'b10, "rd_unmapped");
        write_wait(6'h30, 32'hFFFF_FFFF, 4'hF, 2'b10, "wr_unmapped30");
        write_wait(6'h20, 32'hFFFF_FFFF, 4'hF, 2'b10, "wr_unmapped20");
        check("ctrl0_kept", ctrl[0], 32'd1);
        check("ctrl1_kept", ctrl[1], 32'h0000_CC00);
        check("ctrl2_kept", ctrl[2], 32'd3);
        check("ctrl3_kept", ctrl[3], 32'd4);
        read_wait(6'h1C, 32'h534D_0100, 2'b00, "rd_id");
        write_wait(6'h1C, 32'h0, 4'hF, 2'b00, "wr_id_ro");
        read_wait(6'h1C, 32'h534D_0100, 2'b00, "rd_id_again");
        write_wait(6'h10, 32'h0, 4'hF, 2'b00, "wr_status_ro");
        read_wait(6'h10, 32'h1234_5678, 2'b00, "rd_status");

        // ---- 5: response back-pressure ----
        bready = 1'b0;
        axi_write(6'h08, 32'h0000_0055, 4'hF, 2'b00, "wr_stall");
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check("b_hold", {26'b0, bvalid, bresp, awready, wready, 1'b0}, 32'h20);
            @(posedge clk);
            #1;
        end
        bready = 1'b1;
        wait_b();
        rready = 1'b0;
        axi_read(6'h08, 32'h0000_0055, 2'b00, "rd_stall");
        for (int i = 0; i < 10; i++) begin
            check("r_hold", {rvalid, arready, rresp, rdata[27:0]}, {1'b1, 1'b0, 2'b00, 28'h55});
            @(posedge clk);
            #1;
        end
        rready = 1'b1;
        wait_r();

        // ---- 6: reset while holding an address ----
        send_aw(6'h0C);
        check("have_aw_rdy", {30'b0, awready, wready}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rdy", {30'b0, awready, wready}, 32'd0);
        for (int i = 0; i < 4; i++) check("rst_ctrl_mid", ctrl[i], 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_b_after_rst", {31'b0, bvalid}, 32'd0);
        end
        write_wait(6'h0C, 32'hDEAD_BEEF, 4'hF, 2'b00, "wr_after_rst");
        check("ctrl3_new", ctrl[3], 32'hDEAD_BEEF);
        check("ctrl0_zero", ctrl[0], 32'd0);
        read_wait(6'h0C, 32'hDEAD_BEEF, 2'b00, "rd_after_rst");

        repeat (3) @(posedge clk);
        #1;
        check("queues_empty", 32'(b_q.size() + r_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
